fp_mult_result_checker: RTL and testbench

// - Downstream consumer of the registered FP multiplier outputs (z, status) and the behavioural-model result.
// - Compares each valid result against the model, counts samples and mismatches, and accumulates sticky status flags.
// - Captures the first mismatch and runs a bounded test window under a small FSM, for self-checking benches and on-chip BIST.

---
 rtl/fp_chk_pkg.sv | 28 ++
 rtl/fp_sat_counter.sv | 33 +++
 rtl/fp_mult_result_checker.sv | 146 ++++++++++++++
 tb/tb_fp_mult_result_checker.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_chk_pkg.sv
// Shared types and helpers for the FP multiplier result checker.
//   chk_state_t : checker FSM state encoding (IDLE=0, RUN=1, DONE=2, HALT=3)
//   STATUS_W    : width of the multiplier status bus
//   STAT_*      : status bit positions; bits [7:6] are reserved
//   is_nan()    : single-precision NaN detect (exp all-ones, non-zero fraction)
package fp_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_HALT = 2'd3
  } chk_state_t;

  localparam int STATUS_W     = 8;
  localparam int NUM_FLAGS    = 6;
  localparam int STAT_ZERO    = 0;
  localparam int STAT_INF     = 1;
  localparam int STAT_NAN     = 2;
  localparam int STAT_TINY    = 3;
  localparam int STAT_HUGE    = 4;
  localparam int STAT_INEXACT = 5;

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/fp_sat_counter.sv
// Saturating up-counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear, wins over inc
//   inc        : count by one; holds at all-ones instead of wrapping
//   q          : current count
module fp_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != {W{1'b1}}))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/fp_mult_result_checker.sv
// Result checker for the registered FP multiplier: compares each valid DUT
// result against the model result, counts samples / mismatches / status flags,
// keeps a sticky status OR, captures the first mismatch and sequences a bounded
// test window (IDLE -> RUN -> DONE/HALT -> IDLE).
//   clk, rst               : clock, asynchronous active-low reset
//   start / stop / clear   : run control pulses
//   in_valid, z, z_ref     : sample qualifier, DUT result, model result
//   status                 : DUT status flags for the sample
//   state_o                : FSM state
//   sample_cnt, mismatch_cnt, flag_cnt[5:0] : saturating run counters
//   sticky_status          : OR of all sampled status
//   first_bad_*            : capture of the first mismatch of the run
//   done                   : one-cycle pulse as state_o first shows DONE/HALT
module fp_mult_result_checker
  import fp_chk_pkg::*;
#(
  parameter int   CNT_W       = 32,
  parameter int   N_SAMPLES   = 1024,
  parameter logic HALT_ON_ERR = 1'b0,
  parameter logic NAN_EQUIV   = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           clear,
  input  logic                           in_valid,
  input  logic [31:0]                    z,
  input  logic [31:0]                    z_ref,
  input  logic [STATUS_W-1:0]            status,
  output logic [1:0]                     state_o,
  output logic [CNT_W-1:0]               sample_cnt,
  output logic [CNT_W-1:0]               mismatch_cnt,
  output logic [NUM_FLAGS-1:0][CNT_W-1:0] flag_cnt,
  output logic [STATUS_W-1:0]            sticky_status,
  output logic                           first_bad_vld,
  output logic [CNT_W-1:0]               first_bad_idx,
  output logic [31:0]                    first_bad_z,
  output logic [31:0]                    first_bad_ref,
  output logic                           done
);

  chk_state_t          state_q, state_d;
  logic                done_q, done_d;
  logic [STATUS_W-1:0] sticky_q, sticky_d;
  logic                fb_vld_q, fb_vld_d;
  logic [CNT_W-1:0]    fb_idx_q, fb_idx_d;
  logic [31:0]         fb_z_q, fb_z_d;
  logic [31:0]         fb_ref_q, fb_ref_d;

  logic        sample, match, mismatch, cnt_clr, hit_n;
  logic [63:0] nxt_cnt;

  always_comb begin
    sample   = (state_q == ST_RUN) && in_valid;
    match    = (NAN_EQUIV && is_nan(z) && is_nan(z_ref)) || (z == z_ref);
    mismatch = sample && !match;
    // Counters restart on a run start and are wiped by clear; otherwise
    // they simply stop moving once RUN is left.
    cnt_clr  = ((state_q == ST_IDLE) && start) ||
               (((state_q == ST_DONE) || (state_q == ST_HALT)) && clear);
    // Compared in 64 bits so a full-width count cannot alias N_SAMPLES.
    nxt_cnt  = 64'(sample_cnt) + 64'd1;
    hit_n    = (N_SAMPLES != 0) && (nxt_cnt == 64'(N_SAMPLES));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (mismatch && HALT_ON_ERR)      state_d = ST_HALT;
        else if (stop || (sample && hit_n)) state_d = ST_DONE;
      end
      ST_DONE, ST_HALT: if (clear) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    done_d = (state_q == ST_RUN) && (state_d != ST_RUN);
  end

  always_comb begin
    sticky_d = sticky_q;
    fb_vld_d = fb_vld_q;
    fb_idx_d = fb_idx_q;
    fb_z_d   = fb_z_q;
    fb_ref_d = fb_ref_q;
    if (cnt_clr) begin
      sticky_d = '0;
      fb_vld_d = 1'b0;
      fb_idx_d = '0;
      fb_z_d   = '0;
      fb_ref_d = '0;
    end else begin
      if (sample) sticky_d = sticky_q | status;
      if (mismatch && !fb_vld_q) begin
        fb_vld_d = 1'b1;
        fb_idx_d = sample_cnt;
        fb_z_d   = z;
        fb_ref_d = z_ref;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      done_q   <= 1'b0;
      sticky_q <= '0;
      fb_vld_q <= 1'b0;
      fb_idx_q <= '0;
      fb_z_q   <= '0;
      fb_ref_q <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      sticky_q <= sticky_d;
      fb_vld_q <= fb_vld_d;
      fb_idx_q <= fb_idx_d;
      fb_z_q   <= fb_z_d;
      fb_ref_q <= fb_ref_d;
    end
  end

  fp_sat_counter #(.W(CNT_W)) u_sample_cnt (
    .clk(clk), .rst_n(rst), .clr(cnt_clr), .inc(sample), .q(sample_cnt)
  );

  fp_sat_counter #(.W(CNT_W)) u_mismatch_cnt (
    .clk(clk), .rst_n(rst), .clr(cnt_clr), .inc(mismatch), .q(mismatch_cnt)
  );

  for (genvar i = 0; i < NUM_FLAGS; i++) begin : g_flag
    fp_sat_counter #(.W(CNT_W)) u_flag_cnt (
      .clk(clk), .rst_n(rst), .clr(cnt_clr), .inc(sample && status[i]), .q(flag_cnt[i])
    );
  end

  assign state_o       = state_q;
  assign done          = done_q;
  assign sticky_status = sticky_q;
  assign first_bad_vld = fb_vld_q;
  assign first_bad_idx = fb_idx_q;
  assign first_bad_z   = fb_z_q;
  assign first_bad_ref = fb_ref_q;

endmodule

// File: tb/tb_fp_mult_result_checker.sv
// Bench for fp_mult_result_checker: three instances share one stimulus stream
//   A : N_SAMPLES=4, keep running on error
//   H : N_SAMPLES=8, halt on first error
//   S : CNT_W=3, unbounded run (saturation)
// Each is tracked by a reference model of the run rules and compared every cycle.
module tb_fp_mult_result_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, clear, in_valid;
  logic [31:0] z, z_ref;
  logic [7:0]  status;

  always #5 clk = ~clk;

  logic [1:0]       st_a, st_h, st_s;
  logic [31:0]      sc_a, mc_a, fbi_a, sc_h, mc_h, fbi_h;
  logic [2:0]       sc_s, mc_s, fbi_s;
  logic [5:0][31:0] fc_a, fc_h, fc_s_x;
  logic [5:0][2:0]  fc_s;
  logic [7:0]       sk_a, sk_h, sk_s;
  logic             fbv_a, fbv_h, fbv_s, dn_a, dn_h, dn_s;
  logic [31:0]      fbz_a, fbr_a, fbz_h, fbr_h, fbz_s, fbr_s;

  always_comb for (int i = 0; i < 6; i++) fc_s_x[i] = 32'(fc_s[i]);

  fp_mult_result_checker #(.CNT_W(32), .N_SAMPLES(4), .HALT_ON_ERR(1'b0), .NAN_EQUIV(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .in_valid(in_valid),
    .z(z), .z_ref(z_ref), .status(status), .state_o(st_a), .sample_cnt(sc_a),
    .mismatch_cnt(mc_a), .flag_cnt(fc_a), .sticky_status(sk_a), .first_bad_vld(fbv_a),
    .first_bad_idx(fbi_a), .first_bad_z(fbz_a), .first_bad_ref(fbr_a), .done(dn_a));

  fp_mult_result_checker #(.CNT_W(32), .N_SAMPLES(8), .HALT_ON_ERR(1'b1), .NAN_EQUIV(1'b1)) dut_h (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .in_valid(in_valid),
    .z(z), .z_ref(z_ref), .status(status), .state_o(st_h), .sample_cnt(sc_h),
    .mismatch_cnt(mc_h), .flag_cnt(fc_h), .sticky_status(sk_h), .first_bad_vld(fbv_h),
    .first_bad_idx(fbi_h), .first_bad_z(fbz_h), .first_bad_ref(fbr_h), .done(dn_h));

  fp_mult_result_checker #(.CNT_W(3), .N_SAMPLES(0), .HALT_ON_ERR(1'b0), .NAN_EQUIV(1'b1)) dut_s (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .in_valid(in_valid),
    .z(z), .z_ref(z_ref), .status(status), .state_o(st_s), .sample_cnt(sc_s),
    .mismatch_cnt(mc_s), .flag_cnt(fc_s), .sticky_status(sk_s), .first_bad_vld(fbv_s),
    .first_bad_idx(fbi_s), .first_bad_z(fbz_s), .first_bad_ref(fbr_s), .done(dn_s));

  // ---------------- reference model ----------------
  typedef struct {
    int          st;     // 0 idle, 1 run, 2 done, 3 halt
    longint      samp;
    longint      mis;
    longint      fc[6];
    logic [7:0]  sticky;
    bit          fbv;
    longint      fbi;
    logic [31:0] fbz;
    logic [31:0] fbr;
    bit          done;
  } mdl_t;

  mdl_t ma, mh, ms;
  int   errors = 0;
  int   checks = 0;

  localparam longint MAX32 = 64'hFFFF_FFFF;

  function automatic mdl_t mdl_zero();
    mdl_t m;
    m.st = 0; m.samp = 0; m.mis = 0; m.sticky = '0;
    m.fbv = 0; m.fbi = 0; m.fbz = '0; m.fbr = '0; m.done = 0;
    for (int i = 0; i < 6; i++) m.fc[i] = 0;
    return m;
  endfunction

  function automatic bit nan(logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  function automatic longint sat_inc(longint v, longint maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int n, bit halt, longint maxv,
                                    bit s, bit p, bit c, bit v,
                                    logic [31:0] zz, logic [31:0] zr, logic [7:0] ss);
    mdl_t r;
    bit   bad;
    r = m;
    r.done = 0;
    case (m.st)
      0: if (s) begin r = mdl_zero(); r.st = 1; end
      1: begin
        if (v) begin
          bad = !((nan(zz) && nan(zr)) || (zz == zr));
          r.samp = sat_inc(m.samp, maxv);
          if (bad) begin
            r.mis = sat_inc(m.mis, maxv);
            if (!m.fbv) begin r.fbv = 1; r.fbi = m.samp; r.fbz = zz; r.fbr = zr; end
          end
          r.sticky = m.sticky | ss;
          for (int i = 0; i < 6; i++) if (ss[i]) r.fc[i] = sat_inc(m.fc[i], maxv);
          if (bad && halt)                        r.st = 3;
          else if (p || (n != 0 && m.samp + 1 == n)) r.st = 2;
        end else if (p) r.st = 2;
        if (r.st != 1) r.done = 1;
      end
      default: if (c) r = mdl_zero();
    endcase
    return r;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic check_dut(string p, mdl_t m, logic [1:0] st, logic [63:0] sc, logic [63:0] mc,
                           logic [5:0][31:0] fc, logic [7:0] sk, logic fbv, logic [63:0] fbi,
                           logic [31:0] fbz, logic [31:0] fbr, logic dn);
    chk({p, ".state"},    64'(st),  64'(m.st));
    chk({p, ".samples"},  sc,       m.samp);
    chk({p, ".mismatch"}, mc,       m.mis);
    for (int i = 0; i < 6; i++) chk($sformatf("%s.flag%0d", p, i), 64'(fc[i]), m.fc[i]);
    chk({p, ".sticky"},   64'(sk),  64'(m.sticky));
    chk({p, ".fb_vld"},   64'(fbv), 64'(m.fbv));
    chk({p, ".fb_idx"},   fbi,      m.fbi);
    chk({p, ".fb_z"},     64'(fbz), 64'(m.fbz));
    chk({p, ".fb_ref"},   64'(fbr), 64'(m.fbr));
    chk({p, ".done"},     64'(dn),  64'(m.done));
  endtask

  task automatic check_all();
    check_dut("A", ma, st_a, 64'(sc_a), 64'(mc_a), fc_a,   sk_a, fbv_a, 64'(fbi_a), fbz_a, fbr_a, dn_a);
    check_dut("H", mh, st_h, 64'(sc_h), 64'(mc_h), fc_h,   sk_h, fbv_h, 64'(fbi_h), fbz_h, fbr_h, dn_h);
    check_dut("S", ms, st_s, 64'(sc_s), 64'(mc_s), fc_s_x, sk_s, fbv_s, 64'(fbi_s), fbz_s, fbr_s, dn_s);
  endtask

  // One clock: drive inputs, advance models on the edge, compare 1 time unit later.
  task automatic cyc(bit s, bit p, bit c, bit v, logic [31:0] zz, logic [31:0] zr, logic [7:0] ss);
    start = s; stop = p; clear = c; in_valid = v; z = zz; z_ref = zr; status = ss;
    @(posedge clk);
    ma = mdl_step(ma, 4, 1'b0, MAX32, s, p, c, v, zz, zr, ss);
    mh = mdl_step(mh, 8, 1'b1, MAX32, s, p, c, v, zz, zr, ss);
    ms = mdl_step(ms, 0, 1'b0, 7,     s, p, c, v, zz, zr, ss);
    #1 check_all();
  endtask

  task automatic restart();
    cyc(0, 1, 0, 0, 32'h0, 32'h0, 8'h0);
    cyc(0, 0, 1, 0, 32'h0, 32'h0, 8'h0);
    cyc(1, 0, 0, 0, 32'h0, 32'h0, 8'h0);
  endtask

  initial begin
    logic [31:0] rz, rr;
    int          k;
    ma = mdl_zero(); mh = mdl_zero(); ms = mdl_zero();
    rst = 1'b0; start = 0; stop = 0; clear = 0; in_valid = 0;
    z = '0; z_ref = '0; status = '0;
    repeat (2) @(posedge clk);
    #1 check_all();
    rst = 1'b1;

    // clear/stop in IDLE do nothing; start enters RUN
    cyc(0, 0, 1, 0, 32'h0, 32'h0, 8'h0);
    cyc(1, 0, 0, 0, 32'h0, 32'h0, 8'h0);
    chk("run_after_start", 64'(st_a), 64'd1);

    // four matching samples: A reaches its bound
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 32'h3F800000, 32'h3F800000, 8'h00);
    chk("a_cnt4", 64'(sc_a), 64'd4);
    chk("a_mis0", 64'(mc_a), 64'd0);
    chk("a_done_state", 64'(st_a), 64'd2);
    chk("a_done_pulse", 64'(dn_a), 64'd1);
    cyc(0, 0, 0, 1, 32'h3F800000, 32'h3F800000, 8'h00);
    chk("a_done_once", 64'(dn_a), 64'd0);
    chk("a_frozen", 64'(sc_a), 64'd4);

    // halt on the mismatch at sample index 2
    restart();
    cyc(0, 0, 0, 1, 32'h40000000, 32'h40000000, 8'h00);
    cyc(0, 0, 0, 1, 32'h40000000, 32'h40000000, 8'h00);
    cyc(0, 0, 0, 1, 32'h40000000, 32'h40000001, 8'h00);
    chk("h_halt", 64'(st_h), 64'd3);
    chk("h_done", 64'(dn_h), 64'd1);
    chk("h_mis1", 64'(mc_h), 64'd1);
    chk("h_idx2", 64'(fbi_h), 64'd2);
    chk("h_fbz", 64'(fbz_h), 64'h40000000);
    chk("h_fbr", 64'(fbr_h), 64'h40000001);
    cyc(0, 0, 0, 1, 32'h1, 32'h2, 8'h00);
    cyc(0, 0, 0, 1, 32'h1, 32'h2, 8'h00);
    chk("h_ignored_cnt", 64'(sc_h), 64'd3);
    chk("h_ignored_mis", 64'(mc_h), 64'd1);
    chk("h_keep_fbz", 64'(fbz_h), 64'h40000000);

    // NaN equivalence, signed zero, status accumulation; start+clear in HALT -> IDLE only
    cyc(1, 0, 1, 0, 32'h0, 32'h0, 8'h0);
    chk("h_clear_start_idle", 64'(st_h), 64'd0);
    restart();
    cyc(0, 0, 0, 1, 32'h7FC00000, 32'hFFC00001, 8'h21);
    chk("nan_match", 64'(mc_a), 64'd0);
    cyc(0, 0, 0, 1, 32'h00000000, 32'h80000000, 8'h04);
    chk("zero_sign_mis", 64'(mc_a), 64'd1);
    chk("sticky25", 64'(sk_a), 64'h25);
    chk("flag0", 64'(fc_a[0]), 64'd1);
    chk("flag2", 64'(fc_a[2]), 64'd1);
    chk("flag5", 64'(fc_a[5]), 64'd1);
    chk("nan_fbi", 64'(fbi_a), 64'd1);

    // stop with a valid sample is counted, then DONE
    restart();
    cyc(0, 0, 0, 1, 32'h5, 32'h5, 8'h00);
    cyc(0, 1, 0, 1, 32'h5, 32'h5, 8'h00);
    chk("s_stop_cnt", 64'(sc_s), 64'd2);
    chk("s_stop_done", 64'(st_s), 64'd2);

    // saturation on a 3-bit unbounded run
    restart();
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 32'h1, 32'h2, 8'h08);
    chk("s_mis_sat", 64'(mc_s), 64'd7);
    chk("s_cnt_sat", 64'(sc_s), 64'd7);
    chk("s_flag3_sat", 64'(fc_s[3]), 64'd7);
    chk("s_still_run", 64'(st_s), 64'd1);
    cyc(0, 1, 0, 1, 32'h1, 32'h2, 8'h00);
    chk("s_sat_stop_done", 64'(st_s), 64'd2);
    chk("s_sat_stop_pulse", 64'(dn_s), 64'd1);

    // randomized traffic with random control pulses
    restart();
    for (int i = 0; i < 400; i++) begin
      k = int'($urandom_range(0, 3));
      rr = $urandom;
      case (k)
        0: rz = rr;
        1: rz = $urandom;
        2: begin rz = {$urandom_range(0,1) == 1, 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
                 rr = {$urandom_range(0,1) == 1, 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))}; end
        default: begin rz = 32'h0; rr = 32'h80000000; end
      endcase
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 14) == 0,
          $urandom_range(0, 3) != 0, rz, rr, 8'($urandom));
    end

    // asynchronous reset in the middle of a run
    restart();
    cyc(0, 0, 0, 1, 32'h1, 32'h2, 8'h3F);
    cyc(0, 0, 0, 1, 32'h1, 32'h1, 8'h3F);
    #2 rst = 1'b0;
    ma = mdl_zero(); mh = mdl_zero(); ms = mdl_zero();
    #1 check_all();
    chk("rst_async_cnt", 64'(sc_a), 64'd0);
    chk("rst_async_state", 64'(st_a), 64'd0);
    #2 rst = 1'b1;
    cyc(0, 0, 0, 1, 32'h1, 32'h2, 8'h01);
    chk("rst_needs_start", 64'(sc_a), 64'd0);
    cyc(1, 0, 0, 0, 32'h0, 32'h0, 8'h00);
    cyc(0, 0, 0, 1, 32'h1, 32'h2, 8'h01);
    chk("rst_resume", 64'(sc_a), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // hard bound on runtime
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
